// File: rtl/audio_frame_pkg.sv
// rtl/audio_frame_pkg.sv - shared state type, sample limits and saturating |x| for the frame unpacker
package audio_frame_pkg;

   typedef enum logic [1:0] {S_LEFT, S_RIGHT, S_CALC, S_OUT} unpk_state_t;

   localparam logic [7:0]         UNITY_GAIN = 8'h10;
   localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
   localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

   // |x| that stays representable: the most negative sample folds to the most positive one
   function automatic logic [15:0] sat_abs(input logic [15:0] x);
      if (x == SAMPLE_MIN)
         return SAMPLE_MAX;
      else if (x[15])
         return 16'(-x);
      else
         return x;
   endfunction

endpackage

// File: rtl/sample_gain_sat.sv
// rtl/sample_gain_sat.sv - combinational sample * unsigned gain, arithmetic shift and saturation
module sample_gain_sat #(
   parameter int DATA_WIDTH = 16,
   parameter int GAIN_WIDTH = 8,
   parameter int GAIN_FRAC  = 4
) (
   input  logic [DATA_WIDTH-1:0] sample,
   input  logic [GAIN_WIDTH-1:0] gain,
   output logic [DATA_WIDTH-1:0] y,
   output logic                  sat
);

   localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
   localparam logic signed [PW-1:0] MAX_V = {{(GAIN_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] MIN_V = {{(GAIN_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [PW-1:0] p;
   logic signed [PW-1:0] s;

   // gain gets a zero sign bit so the product stays a signed multiply
   assign p = $signed(sample) * $signed({1'b0, gain});
   assign s = p >>> GAIN_FRAC;

   always_comb begin
      y   = s[DATA_WIDTH-1:0];
      sat = 1'b0;
      if (s > MAX_V) begin
         y   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         sat = 1'b1;
      end else if (s < MIN_V) begin
         y   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/audio_frame_unpacker.sv
// rtl/audio_frame_unpacker.sv - pairs FWFT FIFO samples into gained stereo frames on a valid/ready port
// Optional PEAK_DETECT_EN tracks the peak post-gain magnitude on peak_abs.
module audio_frame_unpacker
   import audio_frame_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int GAIN_WIDTH = 8,
   parameter int GAIN_FRAC  = 4
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  en,
   input  logic                  flush,
   input  logic [GAIN_WIDTH-1:0] gain,
   input  logic                  fifo_rd_vld,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic [DATA_WIDTH-1:0] frame_left,
   output logic [DATA_WIDTH-1:0] frame_right,
   output logic                  clip,
   output logic [DATA_WIDTH-1:0] peak_abs,
   input  logic                  peak_clr
);

   unpk_state_t           state;
   logic [DATA_WIDTH-1:0] l_raw, r_raw;
   logic [DATA_WIDTH-1:0] y_l, y_r;
   logic                  sat_l, sat_r;

   sample_gain_sat #(.DATA_WIDTH(DATA_WIDTH), .GAIN_WIDTH(GAIN_WIDTH), .GAIN_FRAC(GAIN_FRAC))
      u_gain_l (.sample(l_raw), .gain(gain), .y(y_l), .sat(sat_l));

   sample_gain_sat #(.DATA_WIDTH(DATA_WIDTH), .GAIN_WIDTH(GAIN_WIDTH), .GAIN_FRAC(GAIN_FRAC))
      u_gain_r (.sample(r_raw), .gain(gain), .y(y_r), .sat(sat_r));

   // en only gates the start of a frame; once left is taken the right sample is always drained
   always_comb begin
      fifo_rd_en = 1'b0;
      if (rd_rst_n && !flush) begin
         if (state == S_LEFT)
            fifo_rd_en = en & fifo_rd_vld;
         else if (state == S_RIGHT)
            fifo_rd_en = fifo_rd_vld;
      end
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         state       <= S_LEFT;
         frame_valid <= 1'b0;
         clip        <= 1'b0;
         frame_left  <= '0;
         frame_right <= '0;
         l_raw       <= '0;
         r_raw       <= '0;
      end else if (flush) begin
         state       <= S_LEFT;
         frame_valid <= 1'b0;
         clip        <= 1'b0;
      end else begin
         clip <= 1'b0;
         case (state)
            S_LEFT: begin
               if (fifo_rd_en) begin
                  l_raw <= fifo_rd_data;
                  state <= S_RIGHT;
               end
            end
            S_RIGHT: begin
               if (fifo_rd_en) begin
                  r_raw <= fifo_rd_data;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               frame_left  <= y_l;
               frame_right <= y_r;
               frame_valid <= 1'b1;
               clip        <= sat_l | sat_r;
               state       <= S_OUT;
            end
            S_OUT: begin
               if (frame_ready) begin
                  frame_valid <= 1'b0;
                  state       <= S_LEFT;
               end
            end
            default: state <= S_LEFT;
         endcase
      end
   end

`ifdef PEAK_DETECT_EN
   logic [DATA_WIDTH-1:0] peak_q, abs_l, abs_r, peak_cand;

   assign abs_l     = sat_abs(y_l);
   assign abs_r     = sat_abs(y_r);
   assign peak_cand = (abs_l > abs_r) ? abs_l : abs_r;

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n)
         peak_q <= '0;
      else if (peak_clr)
         peak_q <= '0;
      else if (!flush && state == S_CALC && peak_cand > peak_q)
         peak_q <= peak_cand;
   end

   assign peak_abs = peak_q;
`else
   logic unused_peak_clr;
   assign unused_peak_clr = peak_clr;
   assign peak_abs        = '0;
`endif

endmodule
